fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 16-bit RISC pipeline. Owns the program counter, reads the combinational instruction memory, and assembles one- and two-word instructions (opcode word plus 16-bit immediate word) into the `instruction`/`immediate` pair consumed by the decode stage. Handles stall, branch/flush redirect, and, optionally, interrupt injection.

---
 rtl/isa_pkg.sv | 20 ++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit RISC pipeline: opcode encodings,
// the one/two-word instruction classifier and the fetch FSM state type.
package isa_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_NOT  = 5'b00011;
  localparam logic [4:0] OP_IADD = 5'b00111;
  localparam logic [4:0] OP_LDM  = 5'b10100;
  localparam logic [4:0] OP_LDD  = 5'b10101;
  localparam logic [4:0] OP_STD  = 5'b10110;
  localparam logic [4:0] OP_INT  = 5'b11111;

  typedef enum logic {S_OP = 1'b0, S_IMM = 1'b1} fetch_state_t;

  // Opcodes followed by a 16-bit immediate word in memory.
  function automatic logic is_two_word(input logic [4:0] op);
    return (op == OP_IADD) || (op == OP_LDM) || (op == OP_LDD) || (op == OP_STD);
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register. Assembles one- and two-word
// instructions into {instruction, immediate} for decode.
// Optional feature macro: FETCH_INT_EN (interrupt injection via irq).
module fetch_stage
  import isa_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_INT_EN
  input  logic              irq,
`endif
  output logic [15:0]       instruction,
  output logic [15:0]       immediate,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc_next
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       op_hold;
  logic [ADDR_W-1:0] pc_inc;
`ifdef FETCH_INT_EN
  logic              irq_pending;
`endif

  assign imem_addr = pc;
  assign pc_inc    = pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  // PC, fetch FSM and IF/ID register; priority reset > redirect > stall > fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= S_OP;
      op_hold     <= '0;
      instruction <= '0;
      immediate   <= '0;
      if_valid    <= 1'b0;
      if_pc_next  <= '0;
`ifdef FETCH_INT_EN
      irq_pending <= 1'b0;
`endif
    end else begin
`ifdef FETCH_INT_EN
      // Level irq is latched every edge; cleared below only when injected.
      irq_pending <= irq_pending | irq;
`endif
      if (redirect) begin
        // Flush: any half-assembled two-word instruction is dropped.
        pc       <= redirect_pc;
        state    <= S_OP;
        op_hold  <= '0;
        if_valid <= 1'b0;
      end else if (!stall) begin
        case (state)
          S_IMM: begin
            instruction <= op_hold;
            immediate   <= imem_data;
            if_valid    <= 1'b1;
            if_pc_next  <= pc_inc;
            pc          <= pc_inc;
            state       <= S_OP;
          end
          default: begin
`ifdef FETCH_INT_EN
            if (irq_pending) begin
              // Inject INT; the word at PC is refetched next cycle.
              instruction <= {OP_INT, 11'b0};
              immediate   <= 16'(pc);
              if_valid    <= 1'b1;
              if_pc_next  <= pc;
              irq_pending <= 1'b0;
            end else
`endif
            if (is_two_word(imem_data[15:11])) begin
              op_hold  <= imem_data;
              pc       <= pc_inc;
              if_valid <= 1'b0;
              state    <= S_IMM;
            end else begin
              instruction <= imem_data;
              immediate   <= '0;
              if_valid    <= 1'b1;
              if_pc_next  <= pc_inc;
              pc          <= pc_inc;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random
// stall/redirect traffic against an instruction-stream reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        irq;
  logic [15:0] instruction;
  logic [15:0] immediate;
  logic        if_valid;
  logic [15:0] if_pc_next;

  logic [15:0] mem [0:65535];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_stage #(.ADDR_W(16), .RESET_PC(16'h0020)) dut (
    .clk(clk),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
`ifdef FETCH_INT_EN
    .irq(irq),
`endif
    .instruction(instruction),
    .immediate(immediate),
    .if_valid(if_valid),
    .if_pc_next(if_pc_next)
  );

  // Reference model: where we are in the instruction stream.
  logic [15:0] m_pc;
  logic        m_mid;     // opcode of a two-word instruction already consumed
  logic [15:0] m_op;
  logic [15:0] m_instr, m_imm, m_pcn;
  logic        m_valid;
  logic        m_irqp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic two_word(input logic [15:0] w);
    return w[15:11] inside {5'b00111, 5'b10100, 5'b10101, 5'b10110};
  endfunction

  task automatic model_reset();
    m_pc = 16'h0020; m_mid = 0; m_op = 0;
    m_instr = 0; m_imm = 0; m_pcn = 0; m_valid = 0; m_irqp = 0;
  endtask

  task automatic check_all();
    chk("imem_addr",   {16'h0, imem_addr},   {16'h0, m_pc});
    chk("if_valid",    {31'h0, if_valid},    {31'h0, m_valid});
    if (m_valid) begin
      chk("instruction", {16'h0, instruction}, {16'h0, m_instr});
      chk("immediate",   {16'h0, immediate},   {16'h0, m_imm});
      chk("if_pc_next",  {16'h0, if_pc_next},  {16'h0, m_pcn});
    end
  endtask

  // One clock: apply inputs, advance the model, check after the edge.
  task automatic step(input logic st, input logic rd, input logic [15:0] rpc, input logic iq);
    logic [15:0] w;
    logic        nirq;
    stall = st; redirect = rd; redirect_pc = rpc; irq = iq;
`ifdef FETCH_INT_EN
    nirq = m_irqp | iq;
`else
    nirq = 1'b0;
`endif
    w = mem[m_pc];
    if (rd) begin
      m_pc = rpc; m_mid = 0; m_valid = 0;
    end else if (!st) begin
      if (m_mid) begin
        m_instr = m_op; m_imm = w; m_valid = 1; m_pcn = m_pc + 16'd1;
        m_pc = m_pc + 16'd1; m_mid = 0;
      end else if (m_irqp) begin
        m_instr = 16'hF800; m_imm = m_pc; m_valid = 1; m_pcn = m_pc; nirq = 0;
      end else if (two_word(w)) begin
        m_op = w; m_pc = m_pc + 16'd1; m_valid = 0; m_mid = 1;
      end else begin
        m_instr = w; m_imm = 0; m_valid = 1; m_pcn = m_pc + 16'd1;
        m_pc = m_pc + 16'd1;
      end
    end
    m_irqp = nirq;
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    logic [15:0] w, rpc;
    logic        st, rd, iq;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0020] = 16'h1880;   // NOT
    mem[16'h0021] = 16'h0000;   // NOP
    mem[16'h0010] = 16'hA080;   // LDM
    mem[16'h0011] = 16'hBEEF;
    mem[16'h0040] = 16'h1881;
    mem[16'hFFFF] = 16'h1882;
    mem[16'h0000] = 16'h0000;
    mem[16'h0030] = 16'hA080;
    mem[16'h0031] = 16'h1234;
    mem[16'h0032] = 16'h1883;

    stall = 0; redirect = 0; redirect_pc = 0; irq = 0;
    reset = 1;
    model_reset();
    #12;
    chk("rst_addr",  {16'h0, imem_addr}, 32'h20);
    chk("rst_valid", {31'h0, if_valid},  32'h0);
    chk("rst_instr", {16'h0, instruction}, 32'h0);
    chk("rst_imm",   {16'h0, immediate}, 32'h0);
    chk("rst_pcn",   {16'h0, if_pc_next}, 32'h0);
    @(negedge clk); reset = 0;

    // NOT then NOP from RESET_PC
    step(0, 0, 0, 0);
    chk("not_instr", {16'h0, instruction}, 32'h1880);
    chk("not_pcn",   {16'h0, if_pc_next},  32'h21);
    chk("not_addr",  {16'h0, imem_addr},   32'h21);
    step(0, 0, 0, 0);

    // LDM assembly with a 3-cycle stall in S_IMM
    step(0, 1, 16'h0010, 0);
    chk("redir_valid", {31'h0, if_valid}, 32'h0);
    step(0, 0, 0, 0);
    chk("ldm_bubble", {31'h0, if_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      chk("stall_addr", {16'h0, imem_addr}, 32'h11);
    end
    step(0, 0, 0, 0);
    chk("ldm_instr", {16'h0, instruction}, 32'hA080);
    chk("ldm_imm",   {16'h0, immediate},   32'hBEEF);
    chk("ldm_pcn",   {16'h0, if_pc_next},  32'h12);

    // redirect + stall in S_IMM drops the pending LDM
    step(0, 1, 16'h0010, 0);
    step(0, 0, 0, 0);
    step(1, 1, 16'h0040, 0);
    chk("flush_addr",  {16'h0, imem_addr}, 32'h40);
    chk("flush_valid", {31'h0, if_valid},  32'h0);
    step(0, 0, 0, 0);
    chk("after_flush", {16'h0, instruction}, 32'h1881);

    // PC wrap
    step(0, 1, 16'hFFFF, 0);
    step(0, 0, 0, 0);
    chk("wrap_addr", {16'h0, imem_addr},  32'h0);
    chk("wrap_pcn",  {16'h0, if_pc_next}, 32'h0);

`ifdef FETCH_INT_EN
    // irq during S_IMM: immediate completes first, then INT, PC held
    step(0, 1, 16'h0030, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("irq_ldm", {16'h0, immediate}, 32'h1234);
    step(0, 0, 0, 0);
    chk("int_instr", {16'h0, instruction}, 32'hF800);
    chk("int_imm",   {16'h0, immediate},   32'h32);
    chk("int_addr",  {16'h0, imem_addr},   32'h32);
    step(0, 0, 0, 0);
    chk("int_resume", {16'h0, instruction}, 32'h1883);
`endif

    // async reset asserted mid-S_IMM
    step(0, 1, 16'h0010, 0);
    step(0, 0, 0, 0);
    #2 reset = 1;
    #1;
    chk("arst_addr",  {16'h0, imem_addr},  32'h20);
    chk("arst_valid", {31'h0, if_valid},   32'h0);
    chk("arst_instr", {16'h0, instruction}, 32'h0);
    chk("arst_pcn",   {16'h0, if_pc_next}, 32'h0);
    @(posedge clk); #1 reset = 0;
    model_reset();
    step(0, 0, 0, 0);
    chk("arst_first", {16'h0, instruction}, 32'h1880);

    // random traffic with a bias toward two-word opcodes
    for (int i = 0; i < 65536; i += 3) begin
      w = 16'($urandom);
      case ($urandom_range(0, 5))
        0: w[15:11] = 5'b00111;
        1: w[15:11] = 5'b10100;
        2: w[15:11] = 5'b10101;
        3: w[15:11] = 5'b10110;
        default: ;
      endcase
      mem[i] = w;
    end
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(0, 4) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
      iq  = ($urandom_range(0, 11) == 0);
      step(st, rd, rpc, iq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
